// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data memory responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {SZ_WORD = 2'b00, SZ_HALF = 2'b01, SZ_BYTE = 2'b10} mem_size_t;

   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR} resp_state_t;

   localparam int unsigned LAT_CNT_W = 3;

   // Size code 2'b11 is treated the same as a full word.
   function automatic logic is_word_size(logic [1:0] sz);
      return (sz == SZ_WORD) || (sz == 2'b11);
   endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational little-endian lane merge of right-aligned store data into an existing word.
module mem_lane_merge
   import mem_resp_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   output logic [31:0] new_word
);

   always_comb begin
      new_word = old_word;
      case (size)
         SZ_HALF: begin
            if (addr_lo[1]) new_word[31:16] = wdata[15:0];
            else            new_word[15:0]  = wdata[15:0];
         end
         SZ_BYTE: new_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         default: new_word = wdata;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder: fixed-latency word reads, word stores, and read-modify-write sub-word
// stores on an internal word array. Define MEM_ALIGN_CHECK_EN to add the misalign output.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        MemWR,
   input  logic [31:0] addr,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        wack,
   output logic        busy,
`ifdef MEM_ALIGN_CHECK_EN
   output logic        misalign,
`endif
   output logic        drop
);

   logic [31:0] mem [2**ADDR_W];
   logic [31:0] mem_rd_q;

   resp_state_t          state_q, state_d;
   logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
   logic                 rvalid_q, rvalid_d;
   logic                 wack_q, wack_d;
   logic                 busy_q, busy_d;
   logic                 misalign_q, misalign_d;
   logic [ADDR_W-1:0]    lat_idx_q, lat_idx_d;
   logic [1:0]           lat_lo_q, lat_lo_d;
   logic [1:0]           lat_size_q, lat_size_d;
   logic [31:0]          lat_wdata_q, lat_wdata_d;
   logic [31:0]          merge_q, merge_d;

   logic [ADDR_W-1:0] idx_in, rd_idx, mem_wa;
   logic [31:0]       mem_wd, merged;
   logic              mem_we, misalign_hit;
   logic              unused_addr;

   assign idx_in      = addr[ADDR_W+1:2];
   assign unused_addr = ^addr[31:ADDR_W+2];

   // Only stores are checked; loads of any width fetch the containing word.
`ifdef MEM_ALIGN_CHECK_EN
   assign misalign_hit = MemWR && (is_word_size(size) ? (addr[1:0] != 2'b00)
                                                      : (size == SZ_HALF && addr[0]));
   assign misalign     = misalign_q;
`else
   logic unused_misalign;
   assign misalign_hit    = 1'b0;
   assign unused_misalign = misalign_q;
`endif

   mem_lane_merge u_lane_merge (
      .old_word (mem_rd_q),
      .wdata    (lat_wdata_q),
      .size     (lat_size_q),
      .addr_lo  (lat_lo_q),
      .new_word (merged)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rvalid_d    = 1'b0;
      wack_d      = 1'b0;
      misalign_d  = 1'b0;
      lat_idx_d   = lat_idx_q;
      lat_lo_d    = lat_lo_q;
      lat_size_d  = lat_size_q;
      lat_wdata_d = lat_wdata_q;
      merge_d     = merge_q;
      mem_we      = 1'b0;
      mem_wa      = idx_in;
      mem_wd      = wdata;
      rd_idx      = idx_in;
      case (state_q)
         IDLE: begin
            if (req) begin
               lat_idx_d = idx_in;
               if (!MemWR) begin
                  if (READ_LATENCY <= 1) begin
                     rvalid_d = 1'b1;
                  end else begin
                     state_d = RD_WAIT;
                     cnt_d   = LAT_CNT_W'(1);
                  end
               end else if (misalign_hit) begin
                  misalign_d = 1'b1;
               end else if (is_word_size(size)) begin
                  mem_we = 1'b1;
                  wack_d = 1'b1;
               end else begin
                  lat_lo_d    = addr[1:0];
                  lat_size_d  = size;
                  lat_wdata_d = wdata;
                  state_d     = RMW_RD;
               end
            end
         end
         RD_WAIT: begin
            rd_idx = lat_idx_q;
            cnt_d  = cnt_q + LAT_CNT_W'(1);
            if (cnt_d == LAT_CNT_W'(READ_LATENCY)) begin
               rvalid_d = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end
         end
         RMW_RD: begin
            merge_d = merged;
            state_d = RMW_WR;
         end
         RMW_WR: begin
            mem_we  = 1'b1;
            mem_wa  = lat_idx_q;
            mem_wd  = merge_q;
            wack_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rvalid_q    <= 1'b0;
         wack_q      <= 1'b0;
         busy_q      <= 1'b0;
         misalign_q  <= 1'b0;
         lat_idx_q   <= '0;
         lat_lo_q    <= '0;
         lat_size_q  <= '0;
         lat_wdata_q <= '0;
         merge_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rvalid_q    <= rvalid_d;
         wack_q      <= wack_d;
         busy_q      <= busy_d;
         misalign_q  <= misalign_d;
         lat_idx_q   <= lat_idx_d;
         lat_lo_q    <= lat_lo_d;
         lat_size_q  <= lat_size_d;
         lat_wdata_q <= lat_wdata_d;
         merge_q     <= merge_d;
      end
   end

   // Array contents survive reset, but reset blocks any commit on the same edge.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) mem[mem_wa] <= mem_wd;
      mem_rd_q <= mem[rd_idx];
   end

   assign rdata  = rvalid_q ? mem_rd_q : 32'h0;
   assign rvalid = rvalid_q;
   assign wack   = wack_q;
   assign busy   = busy_q;
   assign drop   = req && busy_q && !reset;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (default ADDR_W=10, READ_LATENCY=2).
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset, req, MemWR;
   logic [31:0] addr, wdata, rdata;
   logic [1:0]  size;
   logic        rvalid, wack, busy, drop;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   data_mem_responder dut (
      .clock    (clk),
      .reset    (reset),
      .req      (req),
      .MemWR    (MemWR),
      .addr     (addr),
      .size     (size),
      .wdata    (wdata),
      .rdata    (rdata),
      .rvalid   (rvalid),
      .wack     (wack),
      .busy     (busy),
`ifdef MEM_ALIGN_CHECK_EN
      .misalign (misalign),
`endif
      .drop     (drop)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Word store: wack must appear exactly one cycle after the request.
   task automatic word_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz);
      req = 1'b1; MemWR = 1'b1; addr = a; wdata = d; size = sz;
      #2 chk({tag, "_wack_t0"}, {31'b0, wack}, 32'h0);
      tick();
      req = 1'b0;
      chk({tag, "_wack_t1"}, {31'b0, wack}, 32'h1);
      chk({tag, "_busy_t1"}, {31'b0, busy}, 32'h0);
      tick();
   endtask

   // Sub-word store: wack exactly three cycles after the request, busy in between.
   task automatic sub_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz);
      req = 1'b1; MemWR = 1'b1; addr = a; wdata = d; size = sz;
      tick();
      req = 1'b0;
      chk({tag, "_t1"}, {30'b0, busy, wack}, 32'h2);
      tick();
      chk({tag, "_t2"}, {30'b0, busy, wack}, 32'h2);
      tick();
      chk({tag, "_t3"}, {30'b0, busy, wack}, 32'h1);
      tick();
   endtask

   // Read: rvalid exactly two cycles after the request with the expected word.
   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      req = 1'b1; MemWR = 1'b0; addr = a; size = 2'b00;
      tick();
      req = 1'b0;
      chk({tag, "_t1"}, {30'b0, busy, rvalid}, 32'h2);
      tick();
      chk({tag, "_t2"}, {30'b0, busy, rvalid}, 32'h1);
      chk({tag, "_rdata"}, rdata, exp);
      tick();
      chk({tag, "_t3"}, {31'b0, rvalid}, 32'h0);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; MemWR = 1'b0; addr = '0; wdata = '0; size = '0;
      tick();
      tick();
      reset = 1'b0;
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_flags", {28'b0, rvalid, wack, busy, drop}, 32'h0);
      tick();

      // 1: word store then read
      word_store("st_w10", 32'h10, 32'hDEADBEEF, 2'b00);
      read_chk("rd_10", 32'h10, 32'hDEADBEEF);

      // 2: half store into upper lane
      word_store("st_w04", 32'h04, 32'h11223344, 2'b00);
      sub_store("st_h06", 32'h06, 32'h0000_5566, 2'b01);
      read_chk("rd_04", 32'h04, 32'h55663344);

      // 3: byte store into lane 1; size 2'b11 acts as word
      word_store("st_w08", 32'h08, 32'h00000000, 2'b11);
      sub_store("st_b09", 32'h09, 32'h0000_00AB, 2'b10);
      read_chk("rd_08", 32'h08, 32'h0000AB00);

      // 4: drop while busy, then back-to-back accept in the rvalid cycle
      req = 1'b1; MemWR = 1'b0; addr = 32'h10;
      tick();
      addr = 32'h04;
      #2 chk("b2b_drop", {30'b0, drop, busy}, 32'h3);
      tick();
      chk("b2b_first_rvalid", {30'b0, busy, rvalid}, 32'h1);
      chk("b2b_first_rdata", rdata, 32'hDEADBEEF);
      #2 chk("b2b_nodrop", {31'b0, drop}, 32'h0);
      tick();
      req = 1'b0;
      chk("b2b_second_t1", {30'b0, busy, rvalid}, 32'h2);
      tick();
      chk("b2b_second_rvalid", {31'b0, rvalid}, 32'h1);
      chk("b2b_second_rdata", rdata, 32'h55663344);
      tick();

      // 5: reset during RMW_WR aborts the byte store
      word_store("st_w0c", 32'h0C, 32'h12345678, 2'b00);
      req = 1'b1; MemWR = 1'b1; addr = 32'h0C; wdata = 32'hFF; size = 2'b10;
      tick();
      req = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_rdata", rdata, 32'h0);
      chk("rst_mid_flags", {28'b0, rvalid, wack, busy, drop}, 32'h0);
      tick();
      chk("rst_mid_nowack", {31'b0, wack}, 32'h0);
      read_chk("rd_0c", 32'h0C, 32'h12345678);

      // 6: address wrap and low-bit handling
      word_store("st_w00", 32'h00, 32'hCAFEF00D, 2'b00);
      read_chk("rd_wrap", 32'h1000, 32'hCAFEF00D);
`ifdef MEM_ALIGN_CHECK_EN
      req = 1'b1; MemWR = 1'b1; addr = 32'h02; wdata = 32'hFFFFFFFF; size = 2'b00;
      tick();
      req = 1'b0;
      chk("mis_pulse", {29'b0, misalign, wack, busy}, 32'h4);
      tick();
      chk("mis_clear", {31'b0, misalign}, 32'h0);
      read_chk("rd_mis", 32'h00, 32'hCAFEF00D);
`else
      word_store("st_trunc", 32'h02, 32'h0BADF00D, 2'b00);
      read_chk("rd_trunc", 32'h00, 32'h0BADF00D);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
